mem_fill_check: RTL and testbench

- Sequential controller that sits directly upstream of the 1024x8 single-port RAM (ports adr/d_in/d_out/wr/cs) and drives all of its inputs.
- On command it fills the whole array with an arithmetic byte pattern, reads it back and compares it, or does both in sequence.
- Reports error count and first failing address.
- Replaces ad-hoc bench loops as the team's memory init/self-test stage.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_pat_gen.sv | 33 +++
 rtl/mem_fill_check.sv | 166 ++++++++++++++++
 tb/tb_mem_fill_check.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants, command encodings and FSM state type for the memory
// fill/check controller.
package mem_pkg;

  localparam int AW_DEF    = 10;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 1024;
  localparam int STEP_DEF  = 2;

  localparam logic [1:0] MODE_FILL       = 2'b00;
  localparam logic [1:0] MODE_CHECK      = 2'b01;
  localparam logic [1:0] MODE_FILL_CHECK = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_W_SET = 3'd1,
    ST_W_STB = 3'd2,
    ST_R_SET = 3'd3,
    ST_R_CMP = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

endpackage

// File: rtl/mem_pat_gen.sv
// Arithmetic byte pattern accumulator: load takes the seed, step adds STEP.
// The same generator feeds both the write data and the read-back reference.
module mem_pat_gen #(
  parameter int DW   = 8,
  parameter int STEP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [DW-1:0] seed,
  output logic [DW-1:0] pat
);

  localparam logic [DW-1:0] STEP_W = DW'(STEP);

  logic [DW-1:0] pat_q, pat_d;

  // Load wins over step so a reload at the fill/check boundary is exact.
  always_comb begin
    pat_d = pat_q;
    if (load)      pat_d = seed;
    else if (step) pat_d = pat_q + STEP_W;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pat_q <= '0;
    else        pat_q <= pat_d;
  end

  assign pat = pat_q;

endmodule

// File: rtl/mem_fill_check.sv
// RAM init/self-test controller: fills the array with seed + k*STEP, reads it
// back and counts miscompares, or both in sequence.
module mem_fill_check
  import mem_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int STEP  = STEP_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] seed,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [AW:0]   err_cnt,
  output logic          err_flag,
  output logic [AW-1:0] first_err_adr,
  output logic [AW-1:0] adr,
  output logic [DW-1:0] d_in,
  output logic          wr,
  output logic          cs,
  input  logic [DW-1:0] d_out,
  output state_e        dbg_state
);

  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW-1:0] K_ONE   = AW'(1);
  localparam logic [AW:0]   ERR_ONE = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [DW-1:0] seed_q, seed_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW:0]   err_cnt_q, err_cnt_d;
  logic [AW-1:0] first_q, first_d;
  logic          busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic          wr_q, wr_d, cs_q, cs_d;
  logic          pat_load, pat_step;
  logic [DW-1:0] pat_seed, pat;
  logic          last;

  assign last     = (k_q == LAST);
  assign pat_seed = (state_q == ST_IDLE) ? seed : seed_q;

  mem_pat_gen #(.DW(DW), .STEP(STEP)) u_pat (
    .clk  (clk),
    .rst_n(rst_n),
    .load (pat_load),
    .step (pat_step),
    .seed (pat_seed),
    .pat  (pat)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    seed_d    = seed_q;
    k_d       = k_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    aborted_d = 1'b0;
    pat_load  = 1'b0;
    pat_step  = 1'b0;
    if (state_q != ST_IDLE && abort) begin
      state_d   = ST_IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (mode inside {MODE_FILL, MODE_CHECK, MODE_FILL_CHECK})) begin
            mode_d    = mode;
            seed_d    = seed;
            k_d       = '0;
            err_cnt_d = '0;
            first_d   = '0;
            pat_load  = 1'b1;
            state_d   = (mode == MODE_CHECK) ? ST_R_SET : ST_W_SET;
          end
        end
        ST_W_SET: state_d = ST_W_STB;
        ST_W_STB: begin
          if (last) begin
            if (mode_q == MODE_FILL_CHECK) begin
              k_d      = '0;
              pat_load = 1'b1;
              state_d  = ST_R_SET;
            end else begin
              state_d = ST_FIN;
            end
          end else begin
            k_d      = k_q + K_ONE;
            pat_step = 1'b1;
            state_d  = ST_W_SET;
          end
        end
        ST_R_SET: state_d = ST_R_CMP;
        ST_R_CMP: begin
          if (d_out != pat) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
            if (err_cnt_q == '0) first_d = k_q;
          end
          if (last) begin
            state_d = ST_FIN;
          end else begin
            k_d      = k_q + K_ONE;
            pat_step = 1'b1;
            state_d  = ST_R_SET;
          end
        end
        ST_FIN:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    // Strobes are registered from the next state so they align with it.
    busy_d = state_d inside {ST_W_SET, ST_W_STB, ST_R_SET, ST_R_CMP};
    cs_d   = busy_d;
    wr_d   = (state_d == ST_W_STB);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= '0;
      seed_q    <= '0;
      k_q       <= '0;
      err_cnt_q <= '0;
      first_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      wr_q      <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      seed_q    <= seed_d;
      k_q       <= k_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      wr_q      <= wr_d;
      cs_q      <= cs_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign err_cnt       = err_cnt_q;
  assign err_flag      = (err_cnt_q != '0);
  assign first_err_adr = first_q;
  assign adr           = k_q;
  assign d_in          = (state_q == ST_W_SET || state_q == ST_W_STB) ? pat : '0;
  assign wr            = wr_q;
  assign cs            = cs_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_fill_check.sv
// Bench for mem_fill_check with a behavioural 1024x8 RAM and a scoreboard of
// expected completion results per command.
module tb_mem_fill_check;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;
  localparam int STEP  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, abort;
  logic [1:0]    mode;
  logic [DW-1:0] seed;
  logic          busy, done, aborted, err_flag, wr, cs;
  logic [AW:0]   err_cnt;
  logic [AW-1:0] first_err_adr, adr;
  logic [DW-1:0] d_in, d_out;
  mem_pkg::state_e dbg_state;

  mem_fill_check dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode         (mode),
    .seed         (seed),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .err_cnt      (err_cnt),
    .err_flag     (err_flag),
    .first_err_adr(first_err_adr),
    .adr          (adr),
    .d_in         (d_in),
    .wr           (wr),
    .cs           (cs),
    .d_out        (d_out),
    .dbg_state    (dbg_state)
  );

  // Behavioural RAM; the bench-side port is used only to corrupt words.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] snap [0:DEPTH-1];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_wadr = '0;
  logic [DW-1:0] tb_wdat = '0;

  always @(posedge clk) begin
    if (cs && wr) mem[adr] <= d_in;
    else if (tb_we) mem[tb_wadr] <= tb_wdat;
  end
  assign d_out = mem[adr];

  int n_vec = 0;
  int n_miss = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // wr must only be high with an address that was already stable last cycle.
  logic [AW-1:0] prev_adr = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr) begin
        chk("wr_adr_hold", 32'(adr), 32'(prev_adr));
        chk("wr_with_cs", 32'(cs), 32'd1);
      end
      if (done) done_cnt++;
    end
    prev_adr <= adr;
  end

  task automatic model_check(input logic [DW-1:0] s, output logic [AW:0] cnt,
                             output logic [AW-1:0] first);
    logic [DW-1:0] p;
    cnt = '0;
    first = '0;
    for (int k = 0; k < DEPTH; k++) begin
      p = s + DW'(k * STEP);
      if (mem[k] !== p) begin
        if (cnt == '0) first = AW'(k);
        cnt = cnt + 1'b1;
      end
    end
  endtask

  task automatic tb_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    tb_we = 1'b1; tb_wadr = a; tb_wdat = v;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] m, input logic [DW-1:0] s,
                         input int poke_cyc, input logic with_abort);
    int cyc;
    logic [AW:0] e_cnt;
    logic [AW-1:0] e_first;
    e_cnt = '0;
    e_first = '0;
    if (m == 2'b01) model_check(s, e_cnt, e_first);
    exp_q.push_back((m == 2'b10) ? 32'(4 * DEPTH + 1) : 32'(2 * DEPTH + 1));
    exp_q.push_back(32'(e_cnt));
    exp_q.push_back(32'(e_cnt != '0));
    exp_q.push_back(32'(e_first));
    @(negedge clk);
    start = 1'b1; mode = m; seed = s; abort = with_abort;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    cyc = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (!done && cyc < 6000) begin
      if (cyc == poke_cyc) begin
        start = 1'b1; mode = 2'b01;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", 32'(cyc), exp_q.pop_front());
    chk("err_cnt", 32'(err_cnt), exp_q.pop_front());
    chk("err_flag", 32'(err_flag), exp_q.pop_front());
    chk("first_err_adr", 32'(first_err_adr), exp_q.pop_front());
    chk("busy_in_fin", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int cyc, dc0, diffs;
    logic seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00; seed = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({busy, done, aborted, wr, cs}), 32'd0);
    chk("rst_err", 32'({err_cnt, err_flag, first_err_adr}), 32'd0);
    chk("rst_adr_din", 32'({adr, d_in}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill with seed 0 and a start pulse landing mid-operation.
    dc0 = done_cnt;
    run_cmd(2'b00, 8'h00, 300, 1'b0);
    repeat (3) @(negedge clk);
    chk("single_done", 32'(done_cnt - dc0), 32'd1);
    chk("ram5", 32'(mem[5]), 32'd10);
    chk("ram127", 32'(mem[127]), 32'd254);
    chk("ram128", 32'(mem[128]), 32'd0);
    chk("ram1023", 32'(mem[1023]), 32'd254);

    // Illegal mode is ignored.
    @(negedge clk);
    start = 1'b1; mode = 2'b11;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | busy | done | cs;
    end
    chk("illegal_start", 32'(seen), 32'd0);

    // Abort in IDLE does nothing.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort", 32'({aborted, busy}), 32'd0);

    // Fill-then-check with start and abort together in IDLE.
    run_cmd(2'b10, 8'h35, 0, 1'b1);
    chk("fc_ram0", 32'(mem[0]), 32'h35);
    chk("fc_ram1023", 32'(mem[1023]), 32'h33);

    // Corrupted check.
    run_cmd(2'b00, 8'h00, 0, 1'b0);
    tb_write(10'd300, 8'hFF);
    tb_write(10'd700, 8'h00);
    run_cmd(2'b01, 8'h00, 0, 1'b0);
    chk("corrupt_cnt", 32'(err_cnt), 32'd2);
    chk("corrupt_first", 32'(first_err_adr), 32'd300);
    chk("corrupt_flag", 32'(err_flag), 32'd1);

    // Abort 100 cycles into a fill.
    for (int i = 0; i < DEPTH; i++) snap[i] = mem[i];
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1; mode = 2'b00; seed = 8'h80;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_pulse", 32'(aborted), 32'd1);
    chk("abort_quiet", 32'({busy, wr, cs, done}), 32'd0);
    @(negedge clk);
    chk("abort_one_cycle", 32'(aborted), 32'd0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    diffs = 0;
    for (int i = 60; i < DEPTH; i++) if (mem[i] !== snap[i]) diffs++;
    chk("abort_untouched", 32'(diffs), 32'd0);
    chk("abort_ram49", 32'(mem[49]), 32'hE2);
    chk("abort_ram50", 32'(mem[50]), 32'(snap[50]));

    // Reset in the middle of a check, then a normal check.
    @(negedge clk);
    start = 1'b1; mode = 2'b01; seed = 8'h00;
    @(negedge clk);
    start = 1'b0;
    repeat (700) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 32'({busy, done, aborted, wr, cs}), 32'd0);
    chk("midrst_err", 32'({err_cnt, err_flag, first_err_adr}), 32'd0);
    chk("midrst_adr_din", 32'({adr, d_in}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(2'b01, 8'h00, 0, 1'b0);
    chk("postrst_cnt", 32'(err_cnt), 32'd52);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
